// File: rtl/vision_pkg.sv
// Shared definitions for the vision-test controller: FSM states, key bit positions and
// optotype direction codes.
package vision_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StNewTrial,
      StWait,
      StJudge,
      StDone
   } state_t;

   localparam int unsigned KEY_UP    = 0;
   localparam int unsigned KEY_DOWN  = 1;
   localparam int unsigned KEY_LEFT  = 2;
   localparam int unsigned KEY_RIGHT = 3;
   localparam int unsigned KEY_START = 4;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left.
module lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] lfsr
);

   logic feedback;

   // Taps 8,6,5,4 map to bits 7,5,4,3 of the register.
   assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[6:0], feedback};
      end
   end

endmodule

// File: rtl/vision_test_ctrl.sv
// Vision-test session controller: random optotype per trial, answer judging with timeout,
// per-level scoring and final result. All outputs are registered.
module vision_test_ctrl
   import vision_pkg::*;
#(
   parameter int unsigned N_LEVELS    = 14,
   parameter int unsigned TRIALS      = 5,
   parameter int unsigned PASS_CNT    = 3,
   parameter int unsigned ANS_TIMEOUT = 250000000,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_pulse,
   output logic       show,
   output logic [1:0] dir,
   output logic [3:0] level,
   output logic [2:0] trial_idx,
   output logic [2:0] correct_cnt,
   output logic       answer_ok,
   output logic       answer_bad,
   output logic       done,
   output logic [3:0] result
);

   localparam logic [3:0]  LAST_LEVEL = 4'(N_LEVELS - 1);
   localparam logic [3:0]  ALL_LEVELS = 4'(N_LEVELS);
   localparam logic [2:0]  PASS_N     = 3'(PASS_CNT);
   localparam logic [2:0]  FAIL_LIM   = 3'(TRIALS - PASS_CNT);
   localparam logic [31:0] TIMER_LAST = 32'(ANS_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic        verdict_q, verdict_d;
   logic [7:0]  lfsr;
   logic        unused_lfsr;

   logic [1:0]  dir_d;
   logic [3:0]  level_d, result_d;
   logic [2:0]  trial_d, correct_d;
   logic        show_d, ok_d, bad_d, done_d;

   logic [3:0]  dir_keys;
   logic        start;
   logic [2:0]  trial_inc, correct_inc, wrong_cnt;

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign unused_lfsr = ^lfsr[7:2];

   assign dir_keys    = key_pulse[KEY_RIGHT:KEY_UP];
   assign start       = key_pulse[KEY_START];
   assign trial_inc   = trial_idx + 3'd1;
   assign correct_inc = correct_cnt + {2'b00, verdict_q};
   assign wrong_cnt   = trial_inc - correct_inc;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      verdict_d = verdict_q;
      dir_d     = dir;
      level_d   = level;
      trial_d   = trial_idx;
      correct_d = correct_cnt;
      done_d    = done;
      result_d  = result;

      // Start restarts the session from any state and outranks every other input.
      if (start) begin
         state_d   = StNewTrial;
         level_d   = '0;
         trial_d   = '0;
         correct_d = '0;
         done_d    = 1'b0;
         result_d  = '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
            end
            StNewTrial: begin
               dir_d   = lfsr[1:0];
               timer_d = '0;
               state_d = StWait;
            end
            StWait: begin
               if (dir_keys != 4'b0000) begin
                  // Only a lone bit matching the shown direction counts as correct.
                  verdict_d = (dir_keys == (4'b0001 << dir));
                  state_d   = StJudge;
               end else if (timer_q == TIMER_LAST) begin
                  verdict_d = 1'b0;
                  state_d   = StJudge;
               end else begin
                  timer_d = timer_q + 32'd1;
               end
            end
            StJudge: begin
               trial_d   = trial_inc;
               correct_d = correct_inc;
               if (correct_inc == PASS_N) begin
                  if (level == LAST_LEVEL) begin
                     result_d = ALL_LEVELS;
                     done_d   = 1'b1;
                     state_d  = StDone;
                  end else begin
                     level_d   = level + 4'd1;
                     trial_d   = '0;
                     correct_d = '0;
                     state_d   = StNewTrial;
                  end
               end else if (wrong_cnt > FAIL_LIM) begin
                  result_d = level;
                  done_d   = 1'b1;
                  state_d  = StDone;
               end else begin
                  state_d = StNewTrial;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      // Registered outputs track the state being entered.
      show_d = (state_d == StWait);
      ok_d   = (state_d == StJudge) && verdict_d;
      bad_d  = (state_d == StJudge) && !verdict_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         verdict_q   <= 1'b0;
         show        <= 1'b0;
         dir         <= '0;
         level       <= '0;
         trial_idx   <= '0;
         correct_cnt <= '0;
         answer_ok   <= 1'b0;
         answer_bad  <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         verdict_q   <= verdict_d;
         show        <= show_d;
         dir         <= dir_d;
         level       <= level_d;
         trial_idx   <= trial_d;
         correct_cnt <= correct_d;
         answer_ok   <= ok_d;
         answer_bad  <= bad_d;
         done        <= done_d;
         result      <= result_d;
      end
   end

endmodule
